// File: rtl/dir_key_filter_if.sv
// Key/direction bundle between the raw button pads, the key filter and the game core.
interface dir_key_filter_if;
  logic [3:0] key_raw;
  logic       up;
  logic       down;
  logic       left;
  logic       right;
  logic       key_held;

  modport master (
    output key_raw,
    input  up,
    input  down,
    input  left,
    input  right,
    input  key_held
  );

  modport slave (
    input  key_raw,
    output up,
    output down,
    output left,
    output right,
    output key_held
  );
endinterface

// File: rtl/dir_key_filter.sv
// Synchronizes and debounces four direction buttons and emits one
// registered, mutually exclusive single-cycle pulse per accepted press.
module dir_key_filter #(
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned CNT_W         = 5
) (
  input  logic           clk,
  input  logic           rst,
  dir_key_filter_if.slave keys
);

  localparam int unsigned NKEYS = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  logic [NKEYS-1:0] s1;
  logic [NKEYS-1:0] s2;
  logic [NKEYS-1:0] stable;
  logic [CNT_W-1:0] cnt [NKEYS];

  state_t           state;
  state_t           state_n;
  logic [NKEYS-1:0] pulse;
  logic [NKEYS-1:0] pulse_n;

  // Two-flop synchronizer for the asynchronous button inputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= keys.key_raw;
      s2 <= s1;
    end
  end

  // Per-key debounce: a new level must persist STABLE_CYCLES edges; any break restarts the count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stable <= '0;
      for (int i = 0; i < NKEYS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NKEYS; i++) begin
        if (s2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= s2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      pulse <= '0;
    end else begin
      state <= state_n;
      pulse <= pulse_n;
    end
  end

  // One pulse on the first accepted key (up > down > left > right), then lock until all released
  always_comb begin
    state_n = state;
    pulse_n = '0;
    case (state)
      IDLE: begin
        if (stable != '0) begin
          state_n = HOLD;
          if (stable[3])      pulse_n = 4'b1000;
          else if (stable[2]) pulse_n = 4'b0100;
          else if (stable[1]) pulse_n = 4'b0010;
          else                pulse_n = 4'b0001;
        end
      end
      HOLD: begin
        if (stable == '0) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign keys.up       = pulse[3];
  assign keys.down     = pulse[2];
  assign keys.left     = pulse[1];
  assign keys.right    = pulse[0];
  assign keys.key_held = (state == HOLD);

endmodule

// File: tb/tb_dir_key_filter.sv
// Directed bench for dir_key_filter: default-parameter instance plus a STABLE_CYCLES=2 instance.
module tb_dir_key_filter;

  logic clk;
  logic rst;

  dir_key_filter_if ka ();
  dir_key_filter_if kb ();

  dir_key_filter #(.STABLE_CYCLES(16), .CNT_W(5)) dut_a (
    .clk  (clk),
    .rst  (rst),
    .keys (ka.slave)
  );

  dir_key_filter #(.STABLE_CYCLES(2), .CNT_W(1)) dut_b (
    .clk  (clk),
    .rst  (rst),
    .keys (kb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Pulse tallies observed between edges, plus any cycle with more than one pulse high
  int cnt_up = 0, cnt_down = 0, cnt_left = 0, cnt_right = 0, cnt_multi = 0;
  int cnt_b_down = 0, cnt_b_multi = 0;

  always @(negedge clk) begin
    if (ka.up)    cnt_up++;
    if (ka.down)  cnt_down++;
    if (ka.left)  cnt_left++;
    if (ka.right) cnt_right++;
    if ((32'(ka.up) + 32'(ka.down) + 32'(ka.left) + 32'(ka.right)) > 1) cnt_multi++;
    if (kb.down)  cnt_b_down++;
    if ((32'(kb.up) + 32'(kb.down) + 32'(kb.left) + 32'(kb.right)) > 1) cnt_b_multi++;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int outs_a();
    return {27'd0, ka.up, ka.down, ka.left, ka.right, ka.key_held};
  endfunction

  initial begin
    rst        = 1'b0;
    ka.key_raw = 4'b0000;
    kb.key_raw = 4'b0000;

    // 1: reset and quiet inputs
    #2;
    check_eq("reset_outs_a", outs_a(), 0);
    tick(3);
    rst = 1'b1;
    tick(100);
    check_eq("idle_pulses", cnt_up + cnt_down + cnt_left + cnt_right, 0);
    check_eq("idle_held", 32'(ka.key_held), 0);

    // 2: clean up press, 60 cycles, then release
    ka.key_raw = 4'b1000;
    tick(18);
    check_eq("up_early", 32'(ka.up), 0);
    check_eq("held_early", 32'(ka.key_held), 0);
    tick(1);
    check_eq("up_pulse", 32'(ka.up), 1);
    check_eq("held_rise", 32'(ka.key_held), 1);
    tick(1);
    check_eq("up_fall", 32'(ka.up), 0);
    tick(40);
    ka.key_raw = 4'b0000;
    tick(18);
    check_eq("held_before_release", 32'(ka.key_held), 1);
    tick(1);
    check_eq("held_after_release", 32'(ka.key_held), 0);
    tick(20);
    check_eq("up_count", cnt_up, 1);
    check_eq("others_after_up", cnt_down + cnt_left + cnt_right, 0);

    // 3: bouncing left key, then held
    for (int r = 0; r < 5; r++) begin
      ka.key_raw = 4'b0010;
      tick(10);
      ka.key_raw = 4'b0000;
      tick(3);
    end
    check_eq("bounce_no_pulse", cnt_left, 0);
    check_eq("bounce_no_hold", 32'(ka.key_held), 0);
    ka.key_raw = 4'b0010;
    tick(18);
    check_eq("left_early", cnt_left, 0);
    tick(1);
    check_eq("left_pulse", 32'(ka.left), 1);
    tick(1);
    check_eq("left_fall", 32'(ka.left), 0);
    ka.key_raw = 4'b0000;
    tick(25);
    check_eq("left_released", 32'(ka.key_held), 0);
    check_eq("left_count", cnt_left, 1);

    // 4: down+right together, then up added while held, then right alone
    ka.key_raw = 4'b0101;
    tick(19);
    check_eq("prio_down", 32'(ka.down), 1);
    check_eq("prio_right", 32'(ka.right), 0);
    ka.key_raw = 4'b1101;
    tick(30);
    check_eq("lock_up", cnt_up, 1);
    check_eq("lock_down", cnt_down, 1);
    check_eq("lock_right", cnt_right, 0);
    check_eq("lock_held", 32'(ka.key_held), 1);
    ka.key_raw = 4'b0000;
    tick(20);
    check_eq("prio_released", 32'(ka.key_held), 0);
    ka.key_raw = 4'b0001;
    tick(18);
    check_eq("right_early", cnt_right, 0);
    tick(1);
    check_eq("right_pulse", 32'(ka.right), 1);

    // 5: asynchronous reset mid-cycle while HOLD, key stays pressed
    tick(5);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_eq("async_reset_outs", outs_a(), 0);
    tick(3);
    rst = 1'b1;
    tick(18);
    check_eq("rerun_early", cnt_right, 1);
    check_eq("rerun_held_early", 32'(ka.key_held), 0);
    tick(1);
    check_eq("rerun_pulse", 32'(ka.right), 1);
    tick(1);
    check_eq("rerun_fall", 32'(ka.right), 0);
    ka.key_raw = 4'b0000;
    tick(25);
    check_eq("right_count", cnt_right, 2);
    check_eq("onehot_a", cnt_multi, 0);

    // 6: short debounce instance: 1-cycle glitch rejected, steady press accepted
    kb.key_raw = 4'b0100;
    tick(1);
    kb.key_raw = 4'b0000;
    tick(10);
    check_eq("b_glitch", cnt_b_down, 0);
    check_eq("b_glitch_held", 32'(kb.key_held), 0);
    kb.key_raw = 4'b0100;
    tick(4);
    check_eq("b_early", 32'(kb.down), 0);
    tick(1);
    check_eq("b_pulse", 32'(kb.down), 1);
    tick(1);
    check_eq("b_fall", 32'(kb.down), 0);
    kb.key_raw = 4'b0000;
    tick(10);
    check_eq("b_count", cnt_b_down, 1);
    check_eq("b_onehot", cnt_b_multi, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dir_key_filter.md
# dir_key_filter

Input conditioner for the 2048 game core. Takes the four raw, asynchronous, bouncing direction push-buttons and produces clean, mutually exclusive, single-cycle direction pulses on `up`/`down`/`left`/`right` that drive the game FSM's direction inputs directly. One press yields exactly one move, however long the button is held.

## Interface
Parameters:
- `STABLE_CYCLES`, default 16: consecutive clock edges a synchronized key level must persist before it is accepted. Legal range is 2 or more.
- `CNT_W`, default 5: width of each debounce counter. Must satisfy 2^CNT_W ≥ STABLE_CYCLES.

Ports:
- `clk`  in  1  system clock. Same clock as the game core.
- `rst`  in  1  reset, asynchronous, active-low (0 = reset).
- `key_raw`  in  4  raw buttons `{up, down, left, right}`, bit 3 = up. Asynchronous to `clk`; 1 = pressed.
- `up`  out  1  one-cycle pulse: accepted UP press.
- `down`  out  1  one-cycle pulse: accepted DOWN press.
- `left`  out  1  one-cycle pulse: accepted LEFT press.
- `right`  out  1  one-cycle pulse: accepted RIGHT press.
- `key_held`  out  1  high while the FSM is in HOLD, i.e. waiting for all keys to be released.

## Operation
Each key has its own synchronizer and debouncer:
- **Synchronizer:** two flops per bit, `s1` then `s2`.
- **Debounce state:** registered `stable` bit and `cnt[CNT_W-1:0]`.
- **Debounce rule, evaluated every edge:**
  - If `s2 == stable`: `cnt <= 0`.
  - Else if `cnt == STABLE_CYCLES-1`: `stable <= s2` and `cnt <= 0`.
  - Else: `cnt <= cnt + 1`.
- **Consequence:** a level is accepted only after it differs from `stable` for STABLE_CYCLES consecutive edges. Any shorter excursion is discarded, because the counter restarts from 0.
- **Release:** debounced with the same rule.

Direction FSM:
- **States:** IDLE (encoding 0) and HOLD (encoding 1).
- **IDLE:**
  - If `stable != 4'b0000`: register exactly one pulse, selected by fixed priority up > down > left > right, then go to HOLD.
  - Otherwise stay in IDLE with all pulses 0.
- **HOLD:**
  - All pulses are 0.
  - If `stable == 4'b0000`, go to IDLE. Otherwise stay in HOLD.
  - Further presses, including additional keys pressed while one is held, generate nothing.
- **Outputs:** `up`/`down`/`left`/`right` are registered outputs, never more than one high in any cycle. `key_held` = (state == HOLD).
- **Lost pulses:** a pulse that arrives while the game core is not in its INPUT state is ignored by the core. This block does not queue or retry it. That loss is accepted behaviour.

## Timing
- **Reset (`rst`=0, asynchronous):**
  - `s1`, `s2`, `stable`, `cnt` all 0.
  - State IDLE.
  - `up`/`down`/`left`/`right`/`key_held` = 0 immediately, without waiting for a clock edge.
- **Press latency:** raw rises and is first sampled into `s1` at edge 0, then held clean.
  - `s2`=1 after edge 1.
  - The count runs on edges 2 … STABLE_CYCLES+1.
  - `stable`=1 after edge STABLE_CYCLES+1.
  - The pulse is high after edge STABLE_CYCLES+2 and low after edge STABLE_CYCLES+3.
  - `key_held` rises together with the pulse.
  - With the defaults, the pulse is high during the cycle that follows edge 18.
- **Release latency:** `stable` clears STABLE_CYCLES+2 edges after the first sampled low. HOLD→IDLE occurs on the next edge, where `key_held` falls.
- **Pulse width:** exactly 1 cycle. Pulses are never back-to-back; the minimum spacing is one full release/press debounce cycle.
- **Simultaneous events:**
  - If several `stable` bits become 1 on the same edge, only the highest-priority key pulses.
  - A release and a press of different keys in the same cycle while in HOLD keeps the FSM in HOLD, because `stable` is still non-zero.
- **Reset mid-operation:**
  - An in-flight count or HOLD is abandoned.
  - A key still pressed when `rst` returns to 1 is re-debounced from zero and fires once, STABLE_CYCLES+3 edges after release of reset.
- **Wrap-around:** `cnt` never exceeds STABLE_CYCLES-1, so it cannot wrap.

## Test plan
1. **Reset:** `rst`=0 asserted mid-cycle → all outputs 0 before the next clock edge. `key_raw`=4'b0000 for 100 cycles after release → no pulse, `key_held`=0.
2. **Clean press:** `key_raw`=4'b1000 from edge 0, held 60 cycles, then released → `up`=1 for exactly one cycle, after edge 18. `key_held`=1 until 19 edges after the first sampled low. No further pulses.
3. **Bounce rejection:** toggle `key_raw[1]` (left) with high for 10 cycles / low for 3 cycles ×5, then hold high → no pulse during bouncing. Exactly one `left` pulse, 19 edges after the final rising sample.
4. **Priority and hold lock:** `key_raw`=4'b0101 applied on one edge → only `down` pulses. While held, add bit 3 (up) → no pulse. Release all, then press `right` only → one `right` pulse.
5. **Reset during HOLD:** hold `right`, pulse observed, pull `rst` low for 3 cycles while the key stays pressed → outputs cleared asynchronously. One new `right` pulse 19 edges after `rst` returns to 1.
6. **Short parameter:** with STABLE_CYCLES=2 and CNT_W=1, a 1-cycle glitch → no pulse. A 2-cycle-stable press → pulse after edge 4.
